// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO control bundle.
// master: writer client / read-domain side (drives w_en, rptr, ovf_clr).
// slave : wptr_full_ctrl (drives memory write port, Gray write pointer and flags).
//   w_en         write request from the client
//   rptr         Gray read pointer from the read domain (asynchronous to wclk)
//   ovf_clr      clears the sticky overflow flag
//   waddr        binary memory write address
//   wmem_en      memory write strobe
//   wptr         registered Gray write pointer
//   wfull        registered full flag
//   walmost_full registered, fill level >= AF_LEVEL
//   wlevel       registered fill level, 0..2^ADDR_SIZE
//   wovf         sticky overflow error
interface wptr_full_ctrl_if #(
   parameter int unsigned ADDR_SIZE = 6
);
   logic                 w_en;
   logic [ADDR_SIZE:0]   rptr;
   logic                 ovf_clr;
   logic [ADDR_SIZE-1:0] waddr;
   logic                 wmem_en;
   logic [ADDR_SIZE:0]   wptr;
   logic                 wfull;
   logic                 walmost_full;
   logic [ADDR_SIZE:0]   wlevel;
   logic                 wovf;

   modport master (
      output w_en, rptr, ovf_clr,
      input  waddr, wmem_en, wptr, wfull, walmost_full, wlevel, wovf
   );

   modport slave (
      input  w_en, rptr, ovf_clr,
      output waddr, wmem_en, wptr, wfull, walmost_full, wlevel, wovf
   );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain control for a dual-clock FIFO.
// Holds the binary write address and Gray write pointer, synchronizes the Gray
// read pointer into wclk, and produces registered full / almost-full / level
// flags plus a sticky overflow error.
//   wclk  write-domain clock (rising edge)
//   wrst  synchronous active-high reset
//   bus   wptr_full_ctrl_if slave modport (client, memory and read-pointer signals)
module wptr_full_ctrl #(
   parameter int unsigned ADDR_SIZE   = 6,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AF_LEVEL    = (1 << ADDR_SIZE) - 4
) (
   input logic             wclk,
   input logic             wrst,
   wptr_full_ctrl_if.slave bus
);

   localparam int unsigned PW = ADDR_SIZE + 1;
   localparam logic [PW-1:0] AfLevel = PW'(AF_LEVEL);

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wptr_q, wgray_d;
   logic [PW-1:0] sync_q [SYNC_STAGES];
   logic [PW-1:0] syn_rptr, syn_rbin, level_d;
   logic [PW-1:0] wlevel_q;
   logic          wfull_q, wfull_d;
   logic          waf_q, waf_d;
   logic          wovf_q, wovf_d;
   logic          winc;

   assign syn_rptr = sync_q[SYNC_STAGES-1];

   always_comb begin
      winc    = bus.w_en & ~wfull_q;
      wbin_d  = wbin_q + PW'(winc);
      wgray_d = (wbin_d >> 1) ^ wbin_d;

      // Each binary bit is the XOR of all Gray bits at or above it.
      syn_rbin = '0;
      for (int i = 0; i < int'(PW); i++) begin
         syn_rbin[i] = ^(syn_rptr >> i);
      end

      level_d = wbin_d - syn_rbin;
      waf_d   = (level_d >= AfLevel);

      // Full when the write pointer leads the read pointer by exactly one lap:
      // in Gray form the two MSBs differ and the rest match.
      wfull_d = (wgray_d == {~syn_rptr[PW-1:PW-2], syn_rptr[PW-3:0]});

      // Set has priority over clear.
      wovf_d = (bus.w_en & wfull_q) | (wovf_q & ~bus.ovf_clr);
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= bus.rptr;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin_q   <= '0;
         wptr_q   <= '0;
         wfull_q  <= 1'b0;
         waf_q    <= 1'b0;
         wlevel_q <= '0;
         wovf_q   <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wptr_q   <= wgray_d;
         wfull_q  <= wfull_d;
         waf_q    <= waf_d;
         wlevel_q <= level_d;
         wovf_q   <= wovf_d;
      end
   end

   assign bus.waddr        = wbin_q[ADDR_SIZE-1:0];
   assign bus.wmem_en      = winc;
   assign bus.wptr         = wptr_q;
   assign bus.wfull        = wfull_q;
   assign bus.walmost_full = waf_q;
   assign bus.wlevel       = wlevel_q;
   assign bus.wovf         = wovf_q;

endmodule
